neureka_tcdm_port_aligner: RTL and testbench

Splits one wide NEUREKA streamer memory transaction into MP independent 32-bit TCDM port transactions. It tolerates ports that grant and respond in different cycles, and it reassembles the per-port read data into one wide response. The block sits directly between the accelerator's wide `hci_core` initiator and the MP-port TCDM master interface. It replaces the naive AND-of-grants binding, which is only correct when all banks grant in the same cycle.

---
 rtl/neureka_tcdm_port_aligner.sv | 185 ++++++++++++++++++
 tb/tb_neureka_tcdm_port_aligner.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neureka_tcdm_port_aligner.sv
// Splits one wide streamer transaction into MP 32-bit TCDM port transactions and realigns the replies.
// Define NEUREKA_TCDM_ALIGNER_PERF_EN to build the grant-skew cycle counter on perf_skew_o.
module neureka_tcdm_port_aligner #(
    parameter int unsigned BW        = 128,
    parameter int unsigned MP        = BW / 32,
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              in_req_i,
    output logic              in_gnt_o,
    input  logic [31:0]       in_add_i,
    input  logic              in_wen_i,
    input  logic [BW/8-1:0]   in_be_i,
    input  logic [BW-1:0]     in_data_i,
    output logic              in_r_valid_o,
    output logic [BW-1:0]     in_r_data_o,
    input  logic              in_r_ready_i,
    output logic [MP-1:0]     tcdm_req_o,
    input  logic [MP-1:0]     tcdm_gnt_i,
    output logic [MP*32-1:0]  tcdm_add_o,
    output logic [MP-1:0]     tcdm_wen_o,
    output logic [MP*4-1:0]   tcdm_be_o,
    output logic [MP*32-1:0]  tcdm_data_o,
    input  logic [MP*32-1:0]  tcdm_r_data_i,
    input  logic [MP-1:0]     tcdm_r_valid_i,
    output logic              busy_o,
    output logic [31:0]       perf_skew_o
);

    localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(RSP_DEPTH - 1);

    logic [MP-1:0] pend_q, pend_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [31:0]   fifo_mem_q [MP][RSP_DEPTH];
    logic [31:0]   fifo_mem_d [MP][RSP_DEPTH];
    logic [PW-1:0] wptr_q [MP];
    logic [PW-1:0] wptr_d [MP];
    logic [PW-1:0] rptr_q [MP];
    logic [PW-1:0] rptr_d [MP];
    logic [CW-1:0] fcnt_q [MP];
    logic [CW-1:0] fcnt_d [MP];

    logic          started, issue_ok, req_en, complete, first_gnt, pop;
    logic [MP-1:0] gnt_eff, fifo_nonempty;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        tcdm_add_o = '0;
        for (int i = 0; i < MP; i++) begin
            tcdm_add_o[i*32 +: 32] = in_add_i + 32'(4 * i);
        end
    end

    assign tcdm_wen_o  = {MP{in_wen_i}};
    assign tcdm_be_o   = in_be_i;
    assign tcdm_data_o = in_data_i;

    // Once a wide transaction has started it must finish, so only fresh ones wait for a credit.
    assign started    = ~&pend_q;
    assign issue_ok   = started | (out_cnt_q < DEPTH_C);
    assign req_en     = rst_ni & ~clear_i & in_req_i & issue_ok;
    assign tcdm_req_o = {MP{req_en}} & pend_q;
    assign gnt_eff    = tcdm_gnt_i & tcdm_req_o;
    assign complete   = req_en & ((pend_q & ~gnt_eff) == '0);
    assign first_gnt  = ~started & (|gnt_eff);
    assign in_gnt_o   = complete;
    assign busy_o     = started | (out_cnt_q != '0);

    always_comb begin
        pend_d = pend_q;
        if (complete) begin
            pend_d = '1;
        end else if (req_en) begin
            pend_d = pend_q & ~gnt_eff;
        end
    end

    always_comb begin
        out_cnt_d = out_cnt_q;
        case ({first_gnt, pop})
            2'b10:   out_cnt_d = out_cnt_q + CW'(1);
            2'b01:   out_cnt_d = out_cnt_q - CW'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    always_comb begin
        for (int i = 0; i < MP; i++) begin
            fifo_nonempty[i] = (fcnt_q[i] != '0);
        end
    end

    assign in_r_valid_o = &fifo_nonempty;
    assign pop          = in_r_valid_o & in_r_ready_i;

    always_comb begin
        in_r_data_o = '0;
        for (int i = 0; i < MP; i++) begin
            in_r_data_o[i*32 +: 32] = in_r_valid_o ? fifo_mem_q[i][rptr_q[i]] : 32'h0;
        end
    end

    // Each port queues its own replies; the wide reply pops every head at once.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        for (int i = 0; i < MP; i++) begin
            wptr_d[i] = wptr_q[i];
            rptr_d[i] = rptr_q[i];
            fcnt_d[i] = fcnt_q[i];
            if (tcdm_r_valid_i[i]) begin
                fifo_mem_d[i][wptr_q[i]] = tcdm_r_data_i[i*32 +: 32];
                wptr_d[i] = ptr_inc(wptr_q[i]);
            end
            if (pop) begin
                rptr_d[i] = ptr_inc(rptr_q[i]);
            end
            case ({tcdm_r_valid_i[i], pop})
                2'b10:   fcnt_d[i] = fcnt_q[i] + CW'(1);
                2'b01:   fcnt_d[i] = fcnt_q[i] - CW'(1);
                default: fcnt_d[i] = fcnt_q[i];
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            pend_q    <= '1;
            out_cnt_q <= '0;
            for (int i = 0; i < MP; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                fcnt_q[i] <= '0;
            end
        end else begin
            pend_q    <= pend_d;
            out_cnt_q <= out_cnt_d;
            for (int i = 0; i < MP; i++) begin
                wptr_q[i] <= wptr_d[i];
                rptr_q[i] <= rptr_d[i];
                fcnt_q[i] <= fcnt_d[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        fifo_mem_q <= fifo_mem_d;
    end

`ifdef NEUREKA_TCDM_ALIGNER_PERF_EN
    logic [31:0] perf_q, perf_d;

    // A cycle counts when, after this cycle's grants, the transaction is still only partly granted.
    always_comb begin
        perf_d = perf_q;
        if (~&pend_d && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_skew_o = perf_q;
`else
    assign perf_skew_o = '0;
`endif

`ifndef SYNTHESIS
    clear_while_busy: assert property (@(posedge clk_i) disable iff (!rst_ni) clear_i |-> !busy_o);
`endif

endmodule

// File: tb/tb_neureka_tcdm_port_aligner.sv
// Scoreboard bench for neureka_tcdm_port_aligner: TCDM bank model, wide-level reference memory, response monitor.
module tb_neureka_tcdm_port_aligner;

    localparam int BW = 128;
    localparam int MP = 4;
    localparam int D  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, clear, in_req, in_wen;
    logic [31:0]       in_add;
    logic [BW/8-1:0]   in_be;
    logic [BW-1:0]     in_data;
    logic              in_gnt, in_r_valid, in_r_ready;
    logic [BW-1:0]     in_r_data;
    logic [MP-1:0]     t_req, t_gnt, t_wen, t_rvalid;
    logic [MP*32-1:0]  t_add, t_data, t_rdata;
    logic [MP*4-1:0]   t_be;
    logic              busy;
    logic [31:0]       perf;

    bit            rand_mode;
    logic [MP-1:0] dir_allow, rand_allow;
    bit            dir_ready, rand_ready;
    int            dir_lat [MP];
    int            cyc;

    assign t_gnt      = t_req & (rand_mode ? rand_allow : dir_allow);
    assign in_r_ready = rand_mode ? rand_ready : dir_ready;

    neureka_tcdm_port_aligner #(.BW(BW), .MP(MP), .RSP_DEPTH(D)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .in_req_i(in_req), .in_gnt_o(in_gnt), .in_add_i(in_add), .in_wen_i(in_wen),
        .in_be_i(in_be), .in_data_i(in_data),
        .in_r_valid_o(in_r_valid), .in_r_data_o(in_r_data), .in_r_ready_i(in_r_ready),
        .tcdm_req_o(t_req), .tcdm_gnt_i(t_gnt), .tcdm_add_o(t_add), .tcdm_wen_o(t_wen),
        .tcdm_be_o(t_be), .tcdm_data_o(t_data), .tcdm_r_data_i(t_rdata),
        .tcdm_r_valid_i(t_rvalid), .busy_o(busy), .perf_skew_o(perf)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // ---------------- TCDM bank model (per-port, in-order, variable latency) ----------------
    logic [31:0] bank_mem [logic [31:0]];
    int          rsp_t [MP][$];
    logic [31:0] rsp_d [MP][$];
    int          last_t [MP];

    initial begin : bank
        logic [31:0] a, w;
        int lat, rt;
        t_rvalid   = '0;
        t_rdata    = '0;
        cyc        = 0;
        rand_allow = '0;
        rand_ready = 1'b0;
        for (int i = 0; i < MP; i++) last_t[i] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < MP; i++) rand_allow[i] = ($urandom_range(9) < 7);
            rand_ready = ($urandom_range(9) < 7);
            for (int i = 0; i < MP; i++) begin
                if (rsp_t[i].size() > 0 && rsp_t[i][0] <= cyc) begin
                    t_rvalid[i] = 1'b1;
                    t_rdata[i*32 +: 32] = rsp_d[i].pop_front();
                    void'(rsp_t[i].pop_front());
                end else begin
                    t_rvalid[i] = 1'b0;
                    t_rdata[i*32 +: 32] = $urandom;
                end
            end
            #2;
            for (int i = 0; i < MP; i++) begin
                if (t_req[i] && t_gnt[i]) begin
                    a   = t_add[i*32 +: 32];
                    lat = rand_mode ? int'($urandom_range(1, 4)) : dir_lat[i];
                    w   = bank_mem.exists(a) ? bank_mem[a] : init_word(a);
                    if (t_wen[i]) begin
                        rsp_d[i].push_back(w);
                    end else begin
                        for (int b = 0; b < 4; b++)
                            if (t_be[i*4 + b]) w[b*8 +: 8] = t_data[i*32 + b*8 +: 8];
                        bank_mem[a] = w;
                        rsp_d[i].push_back(32'h0);
                    end
                    rt = (cyc + lat > last_t[i] + 1) ? cyc + lat : last_t[i] + 1;
                    last_t[i] = rt;
                    rsp_t[i].push_back(rt);
                end
            end
        end
    end

    // ---------------- wide-level reference model and scoreboard ----------------
    logic [31:0]   ref_mem [logic [31:0]];
    logic [BW-1:0] sb_q [$];

    function automatic logic [BW-1:0] ref_txn(input logic [31:0] a, input logic wen,
                                              input logic [BW/8-1:0] be, input logic [BW-1:0] d);
        logic [BW-1:0] r;
        logic [31:0] wa, word;
        r = '0;
        for (int p = 0; p < MP; p++) begin
            wa   = a + 32'(4 * p);
            word = ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
            if (wen) begin
                r[p*32 +: 32] = word;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (be[p*4 + b]) word[b*8 +: 8] = d[p*32 + b*8 +: 8];
                ref_mem[wa] = word;
            end
        end
        return r;
    endfunction

    initial begin : monitor
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && in_r_valid && in_r_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected: got 0x%0h expected no response (cycle %0d)", in_r_data, cyc);
                end else begin
                    chk("rsp_data", in_r_data, sb_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic issue(input logic [31:0] a, input logic w, input logic [BW/8-1:0] be,
                         input logic [BW-1:0] d, output int waited);
        waited = 0;
        @(negedge clk);
        in_req = 1'b1; in_add = a; in_wen = w; in_be = be; in_data = d;
        #2;
        while (!in_gnt) begin
            if (waited >= 200) begin
                fail_now("issue_timeout");
                in_req = 1'b0;
                return;
            end
            @(negedge clk);
            #2;
            waited++;
        end
        sb_q.push_back(ref_txn(a, w, be, d));
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        in_req = 1'b0;
        #2;
        while (sb_q.size() != 0 || busy || rsp_t[0].size() != 0 || rsp_t[1].size() != 0 ||
               rsp_t[2].size() != 0 || rsp_t[3].size() != 0) begin
            if (n >= 500) begin
                fail_now("drain_timeout");
                return;
            end
            @(negedge clk);
            #2;
            n++;
        end
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- main stimulus ----------------
    initial begin : main
        int w, c;
        logic [BW-1:0] held;
        rst_n = 1'b0; clear = 1'b0; in_req = 1'b0; in_wen = 1'b1;
        in_add = '0; in_be = '0; in_data = '0;
        rand_mode = 0; dir_allow = '1; dir_ready = 1'b1;
        for (int i = 0; i < MP; i++) dir_lat[i] = 1;

        // reset: requests are suppressed even with in_req high
        @(negedge clk); in_req = 1'b1; in_add = 32'h40;
        @(negedge clk); #2;
        chk("rst_tcdm_req", t_req, '0);
        chk("rst_in_gnt", in_gnt, 0);
        @(negedge clk); rst_n = 1'b1; in_req = 1'b0; #2;
        chk("idle_busy", busy, 0);
        chk("idle_r_valid", in_r_valid, 0);
        chk("idle_r_data", in_r_data, '0);
        chk("idle_perf", perf, 0);

        // all ports grant at once: read at 0x1000
        issue(32'h1000, 1'b1, '1, '0, w);
        chk("imm_wait", w, 0);
        chk("imm_addr", t_add, {32'h100C, 32'h1008, 32'h1004, 32'h1000});
        @(negedge clk); in_req = 1'b0; #2;
        chk("imm_rvalid_early", in_r_valid, 0);
        @(negedge clk); #2;
        chk("imm_rvalid", in_r_valid, 1);
        drain();

        // port 1 grant held off three cycles
        dir_allow = 4'b1101;
        @(negedge clk);
        in_req = 1'b1; in_add = 32'h2000; in_wen = 1'b1; in_be = '1;
        #2;
        chk("skew_req_c0", t_req, 4'b1111);
        chk("skew_gnt_c0", in_gnt, 0);
        for (int k = 1; k < 3; k++) begin
            @(negedge clk); #2;
            chk("skew_req_wait", t_req, 4'b0010);
            chk("skew_gnt_wait", in_gnt, 0);
            chk("skew_busy", busy, 1);
        end
        @(negedge clk); dir_allow = '1; #2;
        chk("skew_gnt_c3", in_gnt, 1);
        if (in_gnt) sb_q.push_back(ref_txn(32'h2000, 1'b1, '1, '0));
        @(negedge clk); in_req = 1'b0; #2;
`ifdef NEUREKA_TCDM_ALIGNER_PERF_EN
        chk("skew_perf", perf, 3);
`else
        chk("skew_perf", perf, 0);
`endif
        drain();

        // port 0 answers two cycles after the others; data held while not ready
        dir_lat[0] = 3;
        dir_ready = 1'b0;
        issue(32'h3000, 1'b1, '1, '0, w);
        @(negedge clk); in_req = 1'b0; #2;
        for (int k = 1; k < 4; k++) begin
            if (k > 1) begin @(negedge clk); #2; end
            chk("slow_p0_rvalid_early", in_r_valid, 0);
        end
        @(negedge clk); #2;
        chk("slow_p0_rvalid", in_r_valid, 1);
        held = in_r_data;
        @(negedge clk); #2;
        chk("slow_p0_hold", in_r_data, held);
        dir_ready = 1'b1;
        dir_lat[0] = 1;
        drain();

        // credits exhausted: third read waits for the first pop
        dir_ready = 1'b0;
        issue(32'h4000, 1'b1, '1, '0, w);
        issue(32'h4010, 1'b1, '1, '0, w);
        chk("credit_b2b_wait", w, 0);
        @(negedge clk);
        in_req = 1'b1; in_add = 32'h4020; in_wen = 1'b1; in_be = '1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #2;
            chk("credit_req_blocked", t_req, '0);
            chk("credit_gnt_blocked", in_gnt, 0);
        end
        @(negedge clk); dir_ready = 1'b1; #2;
        chk("credit_pop_cycle_req", t_req, '0);
        @(negedge clk); dir_ready = 1'b0; #2;
        chk("credit_req_after_pop", t_req, 4'b1111);
        chk("credit_gnt_after_pop", in_gnt, 1);
        if (in_gnt) sb_q.push_back(ref_txn(32'h4020, 1'b1, '1, '0));
        dir_ready = 1'b1;
        drain();

        // address wrap at the top of the space, then write/read back across it
        issue(32'hFFFF_FFF8, 1'b1, '1, '0, w);
        chk("wrap_addr", t_add, {32'h4, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF8});
        issue(32'hFFFF_FFF8, 1'b0, 16'hA5F3, {4{$urandom}}, w);
        issue(32'hFFFF_FFF8, 1'b1, '1, '0, w);
        drain();

        // clear and reset while idle with a request pending on the wide side
        @(negedge clk);
        clear = 1'b1; in_req = 1'b1; in_add = 32'h5000; in_wen = 1'b1;
        #2;
        chk("clear_tcdm_req", t_req, '0);
        chk("clear_in_gnt", in_gnt, 0);
        @(negedge clk); clear = 1'b0; in_req = 1'b0; #2;
        chk("clear_busy", busy, 0);
        chk("clear_perf", perf, 0);
        @(negedge clk); rst_n = 1'b0; in_req = 1'b1; #2;
        chk("rst2_tcdm_req", t_req, '0);
        @(negedge clk); rst_n = 1'b1; in_req = 1'b0; #2;
        chk("rst2_r_valid", in_r_valid, 0);
        chk("rst2_busy", busy, 0);
        issue(32'h5000, 1'b1, '1, '0, w);
        chk("post_clear_wait", w, 0);
        drain();

        // randomized traffic: random grants, latencies, ready and address mix
        rand_mode = 1;
        for (int n = 0; n < 250; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4)
                                            : (32'h100 + 32'($urandom_range(0, 31)) * 4);
            issue(a, 1'($urandom_range(0, 1)), 16'($urandom),
                  {$urandom, $urandom, $urandom, $urandom}, w);
            c = $urandom_range(0, 3);
            if (c == 0) begin
                @(negedge clk); in_req = 1'b0;
            end
        end
        rand_mode = 0;
        dir_ready = 1'b1;
        dir_allow = '1;
        drain();
        chk("final_sb_empty", sb_q.size(), 0);
        chk("final_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
